// File: rtl/weapon_fire_scheduler_if.sv
// Weapon fire scheduler signal bundle: trigger/reload requests in,
// weapon state, shot pulse and ammunition status out.
interface weapon_fire_scheduler_if #(
  parameter int unsigned AMMO_MAX = 8
);
  localparam int unsigned AW = $clog2(AMMO_MAX + 1);

  logic          trig;
  logic          reload_req;
  logic [2:0]    weapon_state;
  logic          fire_pulse;
  logic [AW-1:0] ammo;
  logic          reloading;
  logic          empty;

  modport master (
    output trig, reload_req,
    input  weapon_state, fire_pulse, ammo, reloading, empty
  );

  modport slave (
    input  trig, reload_req,
    output weapon_state, fire_pulse, ammo, reloading, empty
  );
endinterface

// File: rtl/weapon_fire_scheduler.sv
// Weapon fire cycle sequencer: arbitrates fire vs reload, tracks ammo and
// times the firing, recovery and reload phases with one shared timer.
// Optional feature macro: WEAPON_AUTOFIRE_EN (trigger level fires instead
// of trigger rising edge).
module weapon_fire_scheduler #(
  parameter int unsigned AMMO_MAX        = 8,
  parameter int unsigned FIRE_CYCLES     = 4,
  parameter int unsigned COOLDOWN_CYCLES = 6,
  parameter int unsigned RELOAD_CYCLES   = 10
) (
  input logic                    clk,
  input logic                    rst,
  weapon_fire_scheduler_if.slave wif
);

  localparam int unsigned AW    = $clog2(AMMO_MAX + 1);
  localparam int unsigned T_MX1 = (FIRE_CYCLES > COOLDOWN_CYCLES) ? FIRE_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned T_MAX = (T_MX1 > RELOAD_CYCLES) ? T_MX1 : RELOAD_CYCLES;
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] FIRE_LAST   = TW'(FIRE_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LAST   = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0] RELOAD_LAST = TW'(RELOAD_CYCLES - 1);
  localparam logic [AW-1:0] AMMO_FULL   = AW'(AMMO_MAX);

  typedef enum logic [2:0] {
    S_LOADED,
    S_FIRING,
    S_RECOVER,
    S_EMPTY,
    S_RELOAD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] ammo_q, ammo_d;
  logic          trig_q;
  logic          fire_req;
  logic          fire_d, fire_q;
  logic [2:0]    ws_d, ws_q;
  logic          reloading_q, empty_q;

  // Trigger history; set in reset so a trigger held through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trig_q <= 1'b1;
    else      trig_q <= wif.trig;
  end

`ifdef WEAPON_AUTOFIRE_EN
  logic armed_q;

  // Level firing; trig_q only suppresses the first cycle out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= 1'b1;
  end

  assign fire_req = wif.trig & (armed_q | ~trig_q);
`else
  assign fire_req = wif.trig & ~trig_q;
`endif

  // Next-state, timer, ammo and shot-pulse decisions.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ammo_d  = ammo_q;
    fire_d  = 1'b0;
    case (state_q)
      S_LOADED: begin
        if (fire_req && (ammo_q != '0)) begin
          state_d = S_FIRING;
          timer_d = '0;
          ammo_d  = ammo_q - 1'b1;
          fire_d  = 1'b1;
        end else if (wif.reload_req && (ammo_q < AMMO_FULL)) begin
          state_d = S_RELOAD;
          timer_d = '0;
        end
      end
      S_FIRING: begin
        if (timer_q == FIRE_LAST) begin
          state_d = S_RECOVER;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (timer_q == COOL_LAST) begin
          state_d = (ammo_q != '0) ? S_LOADED : S_EMPTY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_EMPTY: begin
        if (wif.reload_req) begin
          state_d = S_RELOAD;
          timer_d = '0;
        end
      end
      S_RELOAD: begin
        if (timer_q == RELOAD_LAST) begin
          state_d = S_LOADED;
          timer_d = '0;
          ammo_d  = AMMO_FULL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOADED;
        timer_d = '0;
      end
    endcase
  end

  // One-hot display code for the state being entered.
  always_comb begin
    ws_d = '0;
    case (state_d)
      S_LOADED:  ws_d = 3'b001;
      S_FIRING:  ws_d = 3'b010;
      S_RECOVER: ws_d = 3'b100;
      default:   ws_d = '0;
    endcase
  end

  // State, timer and registered outputs; outputs decode the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOADED;
      timer_q     <= '0;
      ammo_q      <= AMMO_FULL;
      fire_q      <= 1'b0;
      ws_q        <= 3'b001;
      reloading_q <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ammo_q      <= ammo_d;
      fire_q      <= fire_d;
      ws_q        <= ws_d;
      reloading_q <= (state_d == S_RELOAD);
      empty_q     <= (state_d == S_EMPTY);
    end
  end

  assign wif.weapon_state = ws_q;
  assign wif.fire_pulse   = fire_q;
  assign wif.ammo         = ammo_q;
  assign wif.reloading    = reloading_q;
  assign wif.empty        = empty_q;

endmodule

// File: tb/tb_weapon_fire_scheduler.sv
// Scoreboard bench for weapon_fire_scheduler: stimulus queues the expected
// sequence of output changes (with their hold times); a monitor pops and
// compares each time the output bundle changes.
module tb_weapon_fire_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [9:0] tup;
    int         gap;
    string      name;
  } exp_t;

  exp_t sbq[$];

  weapon_fire_scheduler_if #(.AMMO_MAX(8)) wif ();

  weapon_fire_scheduler #(
    .AMMO_MAX(8),
    .FIRE_CYCLES(4),
    .COOLDOWN_CYCLES(6),
    .RELOAD_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wif(wif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] pack(input logic [2:0] ws, input logic fp,
                                      input int am, input logic rl, input logic em);
    logic [3:0] a;
    a = am[3:0];
    return {ws, fp, a, rl, em};
  endfunction

  // gap = cycles the previous output value must have been held; 0 = don't care
  task automatic exp_ev(input logic [2:0] ws, input logic fp, input int am,
                        input logic rl, input logic em, input int gap, input string nm);
    exp_t e;
    e.tup  = pack(ws, fp, am, rl, em);
    e.gap  = gap;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic exp_shot(input int a, input int g0);
    exp_ev(3'b010, 1'b1, a, 1'b0, 1'b0, g0, "fire_start");
    exp_ev(3'b010, 1'b0, a, 1'b0, 1'b0, 1, "pulse_end");
    exp_ev(3'b100, 1'b0, a, 1'b0, 1'b0, 3, "recover");
    if (a > 0) exp_ev(3'b001, 1'b0, a, 1'b0, 1'b0, 6, "loaded");
    else       exp_ev(3'b000, 1'b0, 0, 1'b0, 1'b1, 6, "empty");
  endtask

  task automatic press();
    @(posedge clk); #1 wif.trig = 1'b1;
    @(posedge clk); #1 wif.trig = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic pulse_reload();
    @(posedge clk); #1 wif.reload_req = 1'b1;
    @(posedge clk); #1 wif.reload_req = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // Shot plus extra trigger presses landing in FIRING and in RECOVER.
  task automatic noisy_press();
    @(posedge clk); #1 wif.trig = 1'b1;
    @(posedge clk); #1 wif.trig = 1'b0;
    @(posedge clk); #1 wif.trig = 1'b1;
    @(posedge clk); #1 wif.trig = 1'b0;
    repeat (3) @(posedge clk); #1 wif.trig = 1'b1;
    @(posedge clk); #1 wif.trig = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Monitor: every change of the output bundle must match the next queued entry.
  initial begin : monitor
    logic [9:0] prev;
    logic [9:0] cur;
    int         last;
    exp_t       e;
    prev = 'x;
    last = 0;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      cur = {wif.weapon_state, wif.fire_pulse, wif.ammo, wif.reloading, wif.empty};
      if (cur !== prev) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got ws=%b fp=%b ammo=%0d rl=%b em=%b at cycle %0d, required no change",
                   cur[9:7], cur[6], cur[5:2], cur[1], cur[0], cyc);
        end else begin
          e = sbq.pop_front();
          if (cur !== e.tup) begin
            n_fail++;
            $display("FAIL %s: got ws=%b fp=%b ammo=%0d rl=%b em=%b, required ws=%b fp=%b ammo=%0d rl=%b em=%b (cycle %0d)",
                     e.name, cur[9:7], cur[6], cur[5:2], cur[1], cur[0],
                     e.tup[9:7], e.tup[6], e.tup[5:2], e.tup[1], e.tup[0], cyc);
          end
          if (e.gap != 0) begin
            n_checks++;
            if (cyc - last != e.gap) begin
              n_fail++;
              $display("FAIL %s_timing: previous value held %0d cycles, required %0d",
                       e.name, cyc - last, e.gap);
            end
          end
        end
        prev = cur;
        last = cyc;
      end
    end
  end

  initial begin : stim
    wif.trig       = 1'b0;
    wif.reload_req = 1'b0;

    exp_ev(3'b001, 1'b0, 8, 1'b0, 1'b0, 0, "reset_state");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Empty the magazine with separate presses.
    for (int i = 7; i >= 0; i--) begin
      exp_shot(i, 0);
      press();
    end

    // Ninth press while empty: nothing happens.
    press();

    // Reload from EMPTY.
    exp_ev(3'b000, 1'b0, 0, 1'b1, 1'b0, 0, "reload_start");
    exp_ev(3'b001, 1'b0, 8, 1'b0, 1'b0, 10, "reload_done");
    pulse_reload();

    // Reload request with full magazine is ignored.
    pulse_reload();

    // Trigger edges during FIRING/RECOVER are dropped.
    exp_shot(7, 0);
    noisy_press();

    // Bring ammo down to 3.
    for (int i = 6; i >= 3; i--) begin
      exp_shot(i, 0);
      press();
    end

    // Fire beats reload in the same cycle.
    exp_shot(2, 0);
    @(posedge clk); #1 wif.trig = 1'b1; wif.reload_req = 1'b1;
    @(posedge clk); #1 wif.trig = 1'b0; wif.reload_req = 1'b0;
    repeat (12) @(posedge clk);

    // Asynchronous reset 4 cycles into RELOAD with trigger held.
    exp_ev(3'b000, 1'b0, 2, 1'b1, 1'b0, 0, "reload_partial");
    exp_ev(3'b001, 1'b0, 8, 1'b0, 1'b0, 4, "async_reset");
    @(posedge clk); #1 wif.reload_req = 1'b1;
    @(posedge clk); #1 wif.reload_req = 1'b0; wif.trig = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
`ifdef WEAPON_AUTOFIRE_EN
    exp_shot(7, 0);
    exp_shot(6, 1);
    repeat (13) @(posedge clk);
    #1 wif.trig = 1'b0;
    repeat (12) @(posedge clk);
`else
    repeat (15) @(posedge clk);
    #1 wif.trig = 1'b0;
`endif
    repeat (5) @(posedge clk);

    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected output changes never seen, required 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
